// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the round-robin UART TX frame scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [7:0] HDR_MARK = 8'hA0;

    localparam int N_REQ_DEFAULT  = 2;
    localparam int DEPTH_DEFAULT  = 4;
    localparam int IDX_W_DEFAULT  = $clog2(N_REQ_DEFAULT);
    localparam int WIDX_W_DEFAULT = $clog2(DEPTH_DEFAULT);

    // Index width that stays at least one bit when there is a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_frame_sched_arb.sv
// Rotating-priority arbiter: grants the first asserted request at or after ptr.
// Purely combinational; no state, no backpressure of its own.
module rr_arbiter_comb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // ptr + k never exceeds 2*N_REQ-2, so one subtraction wraps it.
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                     = 1'b1;
                gnt_idx                 = cand[IDX_W-1:0];
                gnt[cand[IDX_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_sched.sv
// Round-robin scheduler serialising whole frames from N_REQ sources onto one TX byte stream.
// Latency: accept in cycle t -> first word valid in t+1; one IDLE bubble between frames.
// Backpressure: down_ready low holds the current word stable indefinitely. Optional header word: UART_TX_SCHED_HDR_EN.
module uart_tx_frame_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_REQ-1:0]                       req_valid,
    output logic [N_REQ-1:0]                       req_ready,
    input  logic [N_REQ-1:0][DEPTH-1:0][WIDTH-1:0] req_data,
    output logic                                   down_valid,
    input  logic                                   down_ready,
    output logic [WIDTH-1:0]                       down_data,
    output logic [$clog2(N_REQ)-1:0]               grant_id,
    output logic                                   busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int WIDX_W = idx_width(DEPTH);

    state_t                       state_q;
    state_t                       state_d;
    logic [IDX_W-1:0]             rr_ptr;
    logic [N_REQ-1:0]             gnt;
    logic [IDX_W-1:0]             gnt_idx;
    logic                         any;
    logic [WIDX_W-1:0]            word_idx;
    logic [DEPTH-1:0][WIDTH-1:0]  frame_buf;
    logic                         accept;
    logic                         last_word;
    logic                         send_hs;
    logic [WIDTH-1:0]             hdr_mark;
    logic [WIDTH-1:0]             hdr_word;

    rr_arbiter_comb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign hdr_mark  = WIDTH'(HDR_MARK);
    assign hdr_word  = {hdr_mark[WIDTH-1:IDX_W], grant_id};
    assign last_word = (word_idx == WIDX_W'(DEPTH-1));
    assign send_hs   = (state_q == SEND) && down_ready;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        down_valid = 1'b0;
        down_data  = '0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                // gnt only ever marks an asserted request, so any == handshake.
                req_ready = gnt;
                accept    = any;
                if (any) begin
`ifdef UART_TX_SCHED_HDR_EN
                    state_d = HDR;
`else
                    state_d = SEND;
`endif
                end
            end
            HDR: begin
                down_valid = 1'b1;
                down_data  = hdr_word;
                if (down_ready) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                down_valid = 1'b1;
                down_data  = frame_buf[word_idx];
                if (down_ready && last_word) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            word_idx  <= '0;
            grant_id  <= '0;
            frame_buf <= '0;
        end else begin
            if (accept) begin
                frame_buf <= req_data[gnt_idx];
                grant_id  <= gnt_idx;
                word_idx  <= '0;
            end
            if (send_hs) begin
                if (last_word) begin
                    word_idx <= '0;
                    rr_ptr   <= (grant_id == IDX_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

endmodule
